// File: rtl/ansi_term_decoder.sv
// ansi_term_decoder: parses a byte-serial ANSI terminal stream (printable text, ESC[..H/f
// cursor goto, ESC[2J clear, ESC[..m SGR) into one command per cmd handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_data/in_ready  byte input stream (ready/valid)
//   cmd_valid/cmd_ready        command output handshake
//   cmd_op                     0 PUTC, 1 GOTO, 2 CLEAR, 3 SGR
//   cmd_arg0/cmd_arg1          command arguments
//   err                        one-cycle pulse on malformed/unsupported sequence
// Build option: define ANSI_CLAMP_EN to clamp GOTO to the screen and reject SGR codes
// outside {0,1,30..37,40..47}.
module ansi_term_decoder #(
    parameter int unsigned HEIGHT     = 40,
    parameter int unsigned WIDTH      = 80,
    parameter int unsigned MAX_PARAMS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_arg0,
    output logic [7:0] cmd_arg1,
    output logic       err
);

    localparam int unsigned IDX_W = 3;
    localparam logic [7:0] C_ESC  = 8'h1B;
    localparam logic [7:0] C_LBRK = 8'h5B;
    localparam logic [7:0] C_SEMI = 8'h3B;
    localparam logic [7:0] C_H    = 8'h48;
    localparam logic [7:0] C_F    = 8'h66;
    localparam logic [7:0] C_J    = 8'h4A;
    localparam logic [7:0] C_M    = 8'h6D;
    localparam logic [2:0] OP_PUTC  = 3'd0;
    localparam logic [2:0] OP_GOTO  = 3'd1;
    localparam logic [2:0] OP_CLEAR = 3'd2;
    localparam logic [2:0] OP_SGR   = 3'd3;

    if (MAX_PARAMS < 1 || MAX_PARAMS > 4 || HEIGHT < 1 || HEIGHT > 255 ||
        WIDTH < 1 || WIDTH > 255) begin : g_bad_param
        $error("ansi_term_decoder: parameter out of range");
    end

    typedef enum logic [1:0] {S_GROUND, S_ESC, S_CSI, S_EMIT} state_t;

    state_t                r_state, w_state_next;
    logic [7:0]            r_p [MAX_PARAMS];
    logic [7:0]            w_p_n [MAX_PARAMS];
    logic [MAX_PARAMS-1:0] r_pres, w_pres_n, r_pend, w_pend_n;
    logic [IDX_W-1:0]      r_idx, w_idx_n;
    logic                  r_ovf, w_ovf_n;
    logic                  r_valid, w_valid_n, r_err, w_err_n;
    logic [2:0]            r_op, w_op_n;
    logic [7:0]            r_arg0, w_arg0_n, r_arg1, w_arg1_n;

    logic                  w_accept, w_digit, w_semi, w_final, w_multi, w_sgr_ok, w_last_param;
    logic [7:0]            w_cur, w_sat, w_row, w_col, w_first_val, w_pend_val;
    logic [11:0]           w_prod;
    logic [MAX_PARAMS-1:0] w_first_oh, w_pend_oh, w_pend_rest;

    assign in_ready  = ~r_valid & (r_state != S_EMIT);
    assign cmd_valid = r_valid;
    assign cmd_op    = r_op;
    assign cmd_arg0  = r_arg0;
    assign cmd_arg1  = r_arg1;
    assign err       = r_err;

    assign w_accept     = in_valid & in_ready;
    assign w_digit      = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign w_semi       = (in_data == C_SEMI);
    assign w_final      = (in_data >= 8'h40) && (in_data <= 8'h7E);
    assign w_last_param = ((32'(r_idx) + 32'd1) == MAX_PARAMS);

    // Lowest-index present param (first SGR) and lowest still-pending param.
    assign w_first_oh  = r_pres & (~r_pres + MAX_PARAMS'(1));
    assign w_pend_oh   = r_pend & (~r_pend + MAX_PARAMS'(1));
    assign w_pend_rest = r_pend & ~w_pend_oh;
    assign w_multi     = (r_pres & ~w_first_oh) != '0;

`ifdef ANSI_CLAMP_EN
    function automatic logic sgr_legal(input logic [7:0] c);
        return (c == 8'd0) || (c == 8'd1) || (c >= 8'd30 && c <= 8'd37) ||
               (c >= 8'd40 && c <= 8'd47);
    endfunction
`endif

    // Param muxing, digit accumulation and GOTO argument shaping.
    always_comb begin
        w_cur       = '0;
        w_first_val = '0;
        w_pend_val  = '0;
        w_col       = 8'd1;
        w_sgr_ok    = 1'b1;
        for (int i = 0; i < int'(MAX_PARAMS); i++) begin
            if (r_idx == IDX_W'(i))          w_cur       = r_p[i];
            if (w_first_oh[i])               w_first_val = r_p[i];
            if (w_pend_oh[i])                w_pend_val  = r_p[i];
            if (i == 1 && r_p[i] != 8'd0)    w_col       = r_p[i];
`ifdef ANSI_CLAMP_EN
            if (r_pres[i] && !sgr_legal(r_p[i])) w_sgr_ok = 1'b0;
`endif
        end
        w_prod = 12'(w_cur) * 12'd10 + 12'(in_data - 8'h30);
        w_sat  = (w_prod > 12'd255) ? 8'hFF : w_prod[7:0];
        w_row  = (r_p[0] == 8'd0) ? 8'd1 : r_p[0];
`ifdef ANSI_CLAMP_EN
        if (w_row > 8'(HEIGHT)) w_row = 8'(HEIGHT);
        if (w_col > 8'(WIDTH))  w_col = 8'(WIDTH);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_GROUND;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_GROUND: if (w_accept && in_data == C_ESC) w_state_next = S_ESC;
            S_ESC:    if (w_accept) w_state_next = (in_data == C_LBRK) ? S_CSI : S_GROUND;
            S_CSI: begin
                if (w_accept) begin
                    if (in_data == C_ESC)
                        w_state_next = S_ESC;
                    else if (!(w_digit || w_semi))
                        w_state_next = (w_final && in_data == C_M && !r_ovf && w_sgr_ok && w_multi)
                                       ? S_EMIT : S_GROUND;
                end
            end
            S_EMIT:   if (!r_valid && w_pend_rest == '0) w_state_next = S_GROUND;
            default:  w_state_next = S_GROUND;
        endcase
    end

    // Output / datapath next values; a handshake clears cmd_valid for one cycle.
    always_comb begin
        w_valid_n = r_valid & ~cmd_ready;
        w_op_n    = r_op;
        w_arg0_n  = r_arg0;
        w_arg1_n  = r_arg1;
        w_err_n   = 1'b0;
        w_p_n     = r_p;
        w_pres_n  = r_pres;
        w_pend_n  = r_pend;
        w_idx_n   = r_idx;
        w_ovf_n   = r_ovf;
        case (r_state)
            S_GROUND: begin
                if (w_accept && in_data != C_ESC) begin
                    w_valid_n = 1'b1;
                    w_op_n    = OP_PUTC;
                    w_arg0_n  = in_data;
                    w_arg1_n  = 8'd0;
                end
            end
            S_ESC: begin
                if (w_accept) begin
                    if (in_data == C_LBRK) begin
                        for (int i = 0; i < int'(MAX_PARAMS); i++) w_p_n[i] = 8'd0;
                        w_pres_n = '0;
                        w_pend_n = '0;
                        w_idx_n  = '0;
                        w_ovf_n  = 1'b0;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            S_CSI: begin
                if (w_accept) begin
                    if (w_digit) begin
                        // After overflow, digits are swallowed until the final byte.
                        if (!r_ovf) begin
                            for (int i = 0; i < int'(MAX_PARAMS); i++) begin
                                if (r_idx == IDX_W'(i)) begin
                                    w_p_n[i]    = w_sat;
                                    w_pres_n[i] = 1'b1;
                                end
                            end
                        end
                    end else if (w_semi) begin
                        if (w_last_param) w_ovf_n = 1'b1;
                        else              w_idx_n = r_idx + IDX_W'(1);
                    end else if (in_data == C_ESC || !w_final || r_ovf) begin
                        w_err_n = 1'b1;
                    end else if (in_data == C_H || in_data == C_F) begin
                        w_valid_n = 1'b1;
                        w_op_n    = OP_GOTO;
                        w_arg0_n  = w_row;
                        w_arg1_n  = w_col;
                    end else if (in_data == C_J) begin
                        if (r_p[0] == 8'd2) begin
                            w_valid_n = 1'b1;
                            w_op_n    = OP_CLEAR;
                            w_arg0_n  = 8'd0;
                            w_arg1_n  = 8'd0;
                        end else begin
                            w_err_n = 1'b1;
                        end
                    end else if (in_data == C_M && w_sgr_ok) begin
                        // No params yields SGR 0 (w_first_val defaults to 0).
                        w_valid_n = 1'b1;
                        w_op_n    = OP_SGR;
                        w_arg0_n  = w_first_val;
                        w_arg1_n  = 8'd0;
                        w_pend_n  = r_pres & ~w_first_oh;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (!r_valid) begin
                    w_valid_n = 1'b1;
                    w_op_n    = OP_SGR;
                    w_arg0_n  = w_pend_val;
                    w_arg1_n  = 8'd0;
                    w_pend_n  = w_pend_rest;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_arg0  <= '0;
            r_arg1  <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(MAX_PARAMS); i++) r_p[i] <= '0;
            r_pres  <= '0;
            r_pend  <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_valid_n;
            r_op    <= w_op_n;
            r_arg0  <= w_arg0_n;
            r_arg1  <= w_arg1_n;
            r_err   <= w_err_n;
            r_p     <= w_p_n;
            r_pres  <= w_pres_n;
            r_pend  <= w_pend_n;
            r_idx   <= w_idx_n;
            r_ovf   <= w_ovf_n;
        end
    end

endmodule
